// File: rtl/bridge_pkg.sv
// Shared definitions for the UART-to-bus bridge: FSM state encoding and the
// command/response byte values of the serial protocol.
package bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_WRITE,
        S_READ,
        S_RWAIT,
        S_SEND,
        S_ACK
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
    localparam logic [7:0] CMD_HOLD  = 8'h48;  // 'H'
    localparam logic [7:0] CMD_GO    = 8'h47;  // 'G'
    localparam logic [7:0] RSP_OK    = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR   = 8'h45;  // 'E'

endpackage

// File: rtl/uart_bus_bridge.sv
// UART command-stream bus initiator: decodes W/R/H/G byte commands from the
// receive FIFO, runs single-word bus cycles and replies over the transmit FIFO.
module uart_bus_bridge
    import bridge_pkg::*;
#(
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_empty,
    output logic        rd_uart,
    output logic [7:0]  tx_data,
    input  logic        tx_full,
    output logic        wr_uart,
    output logic [29:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        re,
    output logic [3:0]  we,
    output logic        cpu_hold
);

    state_t      state, state_n;
    logic [1:0]  cnt, cnt_n;
    logic        is_write, is_write_n;
    logic        err, err_n;
    logic [31:0] shreg, shreg_n;
    logic [29:0] addr_n;
    logic [31:0] wdata_n;
    logic [7:0]  tx_data_n;
    logic        rd_n, wr_n, hold_n;
    logic        tx_ready;

    // rd_uart/wr_uart are registered: a pop or push is decided one cycle and
    // performed the next, so the strobe cycle is also the byte-capture cycle.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        is_write_n = is_write;
        err_n      = err;
        shreg_n    = shreg;
        addr_n     = addr;
        wdata_n    = wdata;
        tx_data_n  = tx_data;
        hold_n     = cpu_hold;
        rd_n       = 1'b0;
        wr_n       = 1'b0;
        re         = 1'b0;
        we         = '0;
        tx_ready   = !tx_full && !wr_uart;

        case (state)
            S_IDLE: begin
                rd_n = !rx_empty && !rd_uart;
                if (rd_uart) begin
                    case (rx_data)
                        CMD_WRITE: begin
                            is_write_n = 1'b1;
                            err_n      = 1'b0;
                            cnt_n      = '0;
                            state_n    = S_ADDR;
                        end
                        CMD_READ: begin
                            is_write_n = 1'b0;
                            err_n      = 1'b0;
                            cnt_n      = '0;
                            state_n    = S_ADDR;
                        end
                        CMD_HOLD: hold_n = 1'b1;
                        CMD_GO:   hold_n = 1'b0;
                        default:  ;
                    endcase
                end
            end
            S_ADDR: begin
                rd_n = !rx_empty && !rd_uart;
                if (rd_uart) begin
                    shreg_n = {rx_data, shreg[31:8]};
                    cnt_n   = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        addr_n = shreg_n[31:2];
                        if (is_write) begin
                            state_n = S_DATA;
                        end else if (cpu_hold) begin
                            state_n = S_READ;
                        end else begin
                            err_n   = 1'b1;
                            state_n = S_ACK;
                        end
                    end
                end
            end
            S_DATA: begin
                rd_n = !rx_empty && !rd_uart;
                if (rd_uart) begin
                    shreg_n = {rx_data, shreg[31:8]};
                    cnt_n   = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        wdata_n = shreg_n;
                        if (cpu_hold) begin
                            state_n = S_WRITE;
                        end else begin
                            err_n   = 1'b1;
                            state_n = S_ACK;
                        end
                    end
                end
            end
            S_WRITE: begin
                we      = '1;
                state_n = S_ACK;
            end
            S_READ: begin
                re      = 1'b1;
                state_n = S_RWAIT;
            end
            S_RWAIT: begin
                shreg_n = rdata;
                cnt_n   = '0;
                state_n = S_SEND;
            end
            S_SEND: begin
                if (tx_ready) begin
                    wr_n      = 1'b1;
                    tx_data_n = shreg[7:0];
                    shreg_n   = {8'h00, shreg[31:8]};
                    cnt_n     = cnt + 2'd1;
                    if (cnt == 2'd3) state_n = S_IDLE;
                end
            end
            S_ACK: begin
                if (tx_ready) begin
                    wr_n      = 1'b1;
                    tx_data_n = err ? RSP_ERR : RSP_OK;
                    err_n     = 1'b0;
                    state_n   = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_write <= 1'b0;
            err      <= 1'b0;
            shreg    <= '0;
            addr     <= '0;
            wdata    <= '0;
            tx_data  <= '0;
            rd_uart  <= 1'b0;
            wr_uart  <= 1'b0;
            cpu_hold <= HOLD_AT_RESET;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            is_write <= is_write_n;
            err      <= err_n;
            shreg    <= shreg_n;
            addr     <= addr_n;
            wdata    <= wdata_n;
            tx_data  <= tx_data_n;
            rd_uart  <= rd_n;
            wr_uart  <= wr_n;
            cpu_hold <= hold_n;
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed self-checking bench for uart_bus_bridge with UART FIFO and bus memory models.
module tb_uart_bus_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_empty = 1'b1;
    logic        rd_uart;
    logic [7:0]  tx_data;
    logic        tx_full = 1'b0;
    logic        wr_uart;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata = 32'h0;
    logic        re;
    logic [3:0]  we;
    logic        cpu_hold;

    uart_bus_bridge #(.HOLD_AT_RESET(1'b1)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty),
        .rd_uart(rd_uart), .tx_data(tx_data), .tx_full(tx_full), .wr_uart(wr_uart),
        .addr(addr), .wdata(wdata), .rdata(rdata), .re(re), .we(we), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] mem [logic [29:0]];

    int cyc = 0, last_pop_cyc = 0, re_cyc = 0, re_lat = 0, push_lat = 0;
    int re_cnt = 0, we_cnt = 0;
    int rd_on_empty = 0, rd_consec = 0, wr_consec = 0, bus_no_hold = 0, we_bad = 0;
    logic [29:0] last_re_addr = '0, last_we_addr = '0;
    logic [31:0] last_wdata = '0;
    logic rd_prev = 1'b0, wr_prev = 1'b0, push_pending = 1'b0;

    // FIFO, bus memory and protocol monitors
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_prev <= rd_uart;
        wr_prev <= wr_uart;
        if (rd_uart) begin
            if (rx_empty) rd_on_empty <= rd_on_empty + 1;
            if (rd_prev) rd_consec <= rd_consec + 1;
            if (rx_q.size() > 0) void'(rx_q.pop_front());
            last_pop_cyc <= cyc;
        end
        if (wr_uart) begin
            tx_q.push_back(tx_data);
            if (wr_prev) wr_consec <= wr_consec + 1;
            if (push_pending) begin
                push_lat <= cyc - re_cyc;
                push_pending <= 1'b0;
            end
        end
        if (re) begin
            re_cnt <= re_cnt + 1;
            last_re_addr <= addr;
            re_cyc <= cyc;
            re_lat <= cyc - last_pop_cyc;
            push_pending <= 1'b1;
            rdata <= mem.exists(addr) ? mem[addr] : 32'h0;
            if (!cpu_hold) bus_no_hold <= bus_no_hold + 1;
        end
        if (we != 4'h0) begin
            if (we != 4'hF) we_bad <= we_bad + 1;
            we_cnt <= we_cnt + 1;
            last_we_addr <= addr;
            last_wdata <= wdata;
            mem[addr] = wdata;
            if (!cpu_hold) bus_no_hold <= bus_no_hold + 1;
        end
    end

    always @(negedge clk) begin
        rx_empty = (rx_q.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rx_q[0];
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic push_write(input logic [31:0] a, input logic [31:0] d);
        rx_q.push_back(8'h57);
        for (int unsigned i = 0; i < 4; i++) rx_q.push_back(a[8*i +: 8]);
        for (int unsigned i = 0; i < 4; i++) rx_q.push_back(d[8*i +: 8]);
    endtask

    task automatic push_read(input logic [31:0] a);
        rx_q.push_back(8'h52);
        for (int unsigned i = 0; i < 4; i++) rx_q.push_back(a[8*i +: 8]);
    endtask

    task automatic wait_tx(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (tx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_rx_drained();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rx_q.size() == 0) break;
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (rd_uart !== 1'b0) begin n_fail++; $display("FAIL reset_rd_uart: got %b want 0", rd_uart); end
        n_checks++; if (wr_uart !== 1'b0) begin n_fail++; $display("FAIL reset_wr_uart: got %b want 0", wr_uart); end
        n_checks++; if (re !== 1'b0) begin n_fail++; $display("FAIL reset_re: got %b want 0", re); end
        n_checks++; if (we !== 4'h0) begin n_fail++; $display("FAIL reset_we: got %h want 0", we); end
        n_checks++; if (addr !== 30'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", addr); end
        n_checks++; if (wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", wdata); end
        n_checks++; if (tx_data !== 8'h0) begin n_fail++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
        n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold); end
    endtask

    task automatic test_write();
        bit ok;
        int we0 = we_cnt;
        tx_q.delete();
        push_write(32'h0000_0100, 32'hDEAD_BEEF);
        wait_tx(1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL write_tx_timeout: got %0d bytes want 1", tx_q.size()); end
        if (ok) begin
            n_checks++; if (tx_q[0] !== 8'h4B) begin n_fail++; $display("FAIL write_ack: got %h want 4b", tx_q[0]); end
        end
        n_checks++; if (we_cnt - we0 != 1) begin n_fail++; $display("FAIL write_we_count: got %0d want 1", we_cnt - we0); end
        n_checks++; if (last_we_addr !== 30'h40) begin n_fail++; $display("FAIL write_addr: got %h want 40", last_we_addr); end
        n_checks++; if (last_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_wdata: got %h want deadbeef", last_wdata); end
        n_checks++; if (addr !== 30'h40) begin n_fail++; $display("FAIL write_addr_held: got %h want 40", addr); end
    endtask

    task automatic test_read();
        bit ok;
        int re0 = re_cnt;
        logic [7:0] exp [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        mem[30'h40] = 32'h1234_5678;
        tx_q.delete();
        push_read(32'h0000_0100);
        wait_tx(4, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL read_tx_timeout: got %0d bytes want 4", tx_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < tx_q.size()) begin
                n_checks++; if (tx_q[i] !== exp[i]) begin n_fail++; $display("FAIL read_byte%0d: got %h want %h", i, tx_q[i], exp[i]); end
            end
        end
        n_checks++; if (re_cnt - re0 != 1) begin n_fail++; $display("FAIL read_re_count: got %0d want 1", re_cnt - re0); end
        n_checks++; if (last_re_addr !== 30'h40) begin n_fail++; $display("FAIL read_addr: got %h want 40", last_re_addr); end
        n_checks++; if (re_lat != 1) begin n_fail++; $display("FAIL read_re_latency: got %0d want 1", re_lat); end
        n_checks++; if (push_lat < 2) begin n_fail++; $display("FAIL read_push_latency: got %0d want >=2", push_lat); end
    endtask

    task automatic test_no_hold();
        bit ok;
        int we0 = we_cnt;
        int re0 = re_cnt;
        tx_q.delete();
        rx_q.push_back(8'h47);
        push_write(32'h0000_0100, 32'h1111_1111);
        push_read(32'h0000_0100);
        wait_tx(2, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL nohold_tx_timeout: got %0d bytes want 2", tx_q.size()); end
        n_checks++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL nohold_cpu_hold: got %b want 0", cpu_hold); end
        if (ok) begin
            n_checks++; if (tx_q[0] !== 8'h45) begin n_fail++; $display("FAIL nohold_write_reply: got %h want 45", tx_q[0]); end
            n_checks++; if (tx_q[1] !== 8'h45) begin n_fail++; $display("FAIL nohold_read_reply: got %h want 45", tx_q[1]); end
        end
        n_checks++; if (we_cnt != we0) begin n_fail++; $display("FAIL nohold_we: got %0d writes want 0", we_cnt - we0); end
        n_checks++; if (re_cnt != re0) begin n_fail++; $display("FAIL nohold_re: got %0d reads want 0", re_cnt - re0); end
        rx_q.push_back(8'h48);
        wait_rx_drained();
        n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL hold_restore: got %b want 1", cpu_hold); end
        n_checks++; if (tx_q.size() != 2) begin n_fail++; $display("FAIL hold_no_reply: got %0d bytes want 2", tx_q.size()); end
    endtask

    task automatic test_stall();
        bit ok;
        logic [7:0] exp [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        mem[30'h10] = 32'hA1B2_C3D4;
        tx_q.delete();
        tx_full = 1'b1;
        push_read(32'h0000_0040);
        wait_rx_drained();
        repeat (50) @(negedge clk);
        n_checks++; if (tx_q.size() != 0) begin n_fail++; $display("FAIL stall_no_push: got %0d bytes want 0", tx_q.size()); end
        tx_full = 1'b0;
        wait_tx(4, ok);
        n_checks++; if (tx_q.size() != 4) begin n_fail++; $display("FAIL stall_count: got %0d bytes want 4", tx_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < tx_q.size()) begin
                n_checks++; if (tx_q[i] !== exp[i]) begin n_fail++; $display("FAIL stall_byte%0d: got %h want %h", i, tx_q[i], exp[i]); end
            end
        end
    endtask

    task automatic test_garbage();
        bit ok;
        int re0 = re_cnt;
        logic [7:0] exp [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        tx_q.delete();
        rx_q.push_back(8'h00);
        rx_q.push_back(8'hFF);
        push_read(32'h0000_0100);
        wait_tx(4, ok);
        n_checks++; if (tx_q.size() != 4) begin n_fail++; $display("FAIL garbage_count: got %0d bytes want 4", tx_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < tx_q.size()) begin
                n_checks++; if (tx_q[i] !== exp[i]) begin n_fail++; $display("FAIL garbage_byte%0d: got %h want %h", i, tx_q[i], exp[i]); end
            end
        end
        n_checks++; if (re_cnt - re0 != 1) begin n_fail++; $display("FAIL garbage_re_count: got %0d want 1", re_cnt - re0); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int we0 = we_cnt;
        tx_q.delete();
        rx_q.push_back(8'h57);
        rx_q.push_back(8'h00);
        rx_q.push_back(8'h01);
        wait_rx_drained();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++; if (we_cnt != we0) begin n_fail++; $display("FAIL midreset_we: got %0d writes want 0", we_cnt - we0); end
        n_checks++; if (tx_q.size() != 0) begin n_fail++; $display("FAIL midreset_tx: got %0d bytes want 0", tx_q.size()); end
        n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL midreset_hold: got %b want 1", cpu_hold); end
        push_write(32'h0000_0044, 32'hCAFE_F00D);
        wait_tx(1, ok);
        n_checks++; if (tx_q.size() != 1) begin n_fail++; $display("FAIL midreset_retry_count: got %0d bytes want 1", tx_q.size()); end
        if (tx_q.size() > 0) begin
            n_checks++; if (tx_q[0] !== 8'h4B) begin n_fail++; $display("FAIL midreset_retry_ack: got %h want 4b", tx_q[0]); end
        end
        n_checks++; if (last_we_addr !== 30'h11) begin n_fail++; $display("FAIL midreset_retry_addr: got %h want 11", last_we_addr); end
        n_checks++; if (last_wdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL midreset_retry_wdata: got %h want cafef00d", last_wdata); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] exp [5] = '{8'h4B, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
        tx_q.delete();
        push_write(32'h0000_0200, 32'h0BAD_F00D);
        push_read(32'h0000_0200);
        wait_tx(5, ok);
        n_checks++; if (tx_q.size() != 5) begin n_fail++; $display("FAIL b2b_count: got %0d bytes want 5", tx_q.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < tx_q.size()) begin
                n_checks++; if (tx_q[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, tx_q[i], exp[i]); end
            end
        end
        n_checks++; if (last_re_addr !== 30'h80) begin n_fail++; $display("FAIL b2b_read_addr: got %h want 80", last_re_addr); end
    endtask

    task automatic test_protocol();
        n_checks++; if (rd_on_empty != 0) begin n_fail++; $display("FAIL proto_rd_on_empty: got %0d want 0", rd_on_empty); end
        n_checks++; if (rd_consec != 0) begin n_fail++; $display("FAIL proto_rd_consecutive: got %0d want 0", rd_consec); end
        n_checks++; if (wr_consec != 0) begin n_fail++; $display("FAIL proto_wr_consecutive: got %0d want 0", wr_consec); end
        n_checks++; if (bus_no_hold != 0) begin n_fail++; $display("FAIL proto_bus_without_hold: got %0d want 0", bus_no_hold); end
        n_checks++; if (we_bad != 0) begin n_fail++; $display("FAIL proto_partial_we: got %0d want 0", we_bad); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_no_hold();
        test_stall();
        test_garbage();
        test_reset_mid();
        test_back_to_back();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
